// File: rtl/lif_pkg.sv
// Shared types and constants for the lif neuron front end.
package lif_pkg;

    localparam int CUR_MAX = 255;
    localparam int SUM_W   = 11;

    typedef logic signed [3:0] weight_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } syn_state_e;

endpackage

// File: rtl/syn_sat_add.sv
// Decay, weighted spike sum and 0..255 clamp for the synaptic accumulator.
module syn_sat_add
    import lif_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int W_WIDTH     = 4,
    parameter int WSCALE      = 3,
    parameter int DECAY_SHIFT = 1
) (
    input  logic [7:0]                    syn,
    input  logic [N_IN-1:0]               spikes,
    input  logic [N_IN-1:0][W_WIDTH-1:0]  weights,
    output logic [7:0]                    nxt,
    output logic                          clamp_hi,
    output logic                          clamp_lo
);

    localparam logic [SUM_W-1:0] ROUND =
        SUM_W'((1 << DECAY_SHIFT) - 1);
    localparam logic signed [SUM_W-1:0] HI = SUM_W'(CUR_MAX);

    logic        [SUM_W-1:0] syn_x;
    logic        [SUM_W-1:0] decay;
    logic signed [SUM_W-1:0] w_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] t;

    always_comb begin
        syn_x = {{(SUM_W-8){1'b0}}, syn};
        // rounding up lets the accumulator reach 0 instead of sticking at 1
        decay = (syn_x + ROUND) >> DECAY_SHIFT;
        sum   = '0;
        w_ext = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_ext = $signed({{(SUM_W-W_WIDTH){weights[i][W_WIDTH-1]}},
                             weights[i]});
            if (spikes[i]) begin
                sum = sum + (w_ext <<< WSCALE);
            end
        end
        t        = $signed(syn_x - decay) + sum;
        clamp_lo = t[SUM_W-1];
        clamp_hi = !clamp_lo && (t > HI);
        nxt      = clamp_lo ? 8'd0
                 : clamp_hi ? 8'(CUR_MAX)
                 : t[7:0];
    end

endmodule

// File: rtl/lif_synapse.sv
// Presynaptic front end: weighted spikes into a decaying, saturating
// 8-bit current for the lif neuron.
module lif_synapse
    import lif_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int W_WIDTH     = 4,
    parameter int WSCALE      = 3,
    parameter int DECAY_SHIFT = 1,
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_IN-1:0]    spike_in,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [W_WIDTH-1:0] cfg_weight,
    output logic [7:0]         current,
    output logic               busy,
    output logic               sat_hi,
    output logic               sat_lo
);

    syn_state_e state, state_nx;

    logic [N_IN-1:0][W_WIDTH-1:0] weights;
    logic [N_IN-1:0]              spikes;
    logic [7:0]                   nxt;
    logic                         clamp_hi, clamp_lo;
    logic                         act, cfg_we;

    syn_sat_add #(
        .N_IN        (N_IN),
        .W_WIDTH     (W_WIDTH),
        .WSCALE      (WSCALE),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_add (
        .syn      (current),
        .spikes   (spikes),
        .weights  (weights),
        .nxt      (nxt),
        .clamp_hi (clamp_hi),
        .clamp_lo (clamp_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = FLUSH;
            FLUSH: begin
                if (en)             state_nx = RUN;
                else if (nxt == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == IDLE);
        act       = (state != IDLE);
        spikes    = (state == RUN) ? spike_in : '0;
        cfg_we    = cfg_valid && cfg_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            current <= '0;
            busy    <= 1'b0;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
            weights <= '0;
        end else begin
            busy <= (state_nx != IDLE);
            if (act) begin
                current <= nxt;
                sat_hi  <= sat_hi | clamp_hi;
                sat_lo  <= sat_lo | clamp_lo;
            end
            // addresses beyond N_IN match no slot and are dropped
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_we && cfg_addr == AW'(i)) begin
                    weights[i] <= cfg_weight;
                end
            end
        end
    end

endmodule
